channel_arbiter_16: RTL and testbench

CHANNEL_ARBITER_16 -- requirements
Module: channel_arbiter_16

---
 rtl/channel_arbiter_16_pkg.sv | 14 +
 rtl/channel_arbiter_16_prio_enc.sv | 20 ++
 rtl/channel_arbiter_16.sv | 137 +++++++++++++
 tb/tb_channel_arbiter_16.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_arbiter_16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin channel arbiter.
package channel_arbiter_16_pkg;

  localparam int unsigned N_REQ            = 16;
  localparam int unsigned IDX_W            = 4;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned HOLD_MAX_DEFAULT = 255;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

endpackage

// File: rtl/channel_arbiter_16_prio_enc.sv
// 16-to-4 lowest-index-first priority encoder with a valid flag.
module arb_prio_enc16
  import channel_arbiter_16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/channel_arbiter_16.sv
// Round-robin arbiter over 16 level-sensitive requesters with a one-cycle release gap.
// Optional forced-revoke hold timer enabled by defining ARB_TIMEOUT_EN.
module channel_arbiter_16
  import channel_arbiter_16_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("channel_arbiter_16: HOLD_MAX must be within 1..255");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;

  logic [N_REQ-1:0] req_masked;
  logic [IDX_W-1:0] masked_idx, all_idx, sel_idx;
  logic             masked_valid, all_valid;
  logic             release_evt;
  logic             hold_expired;

  assign req_masked = req & ({N_REQ{1'b1}} << ptr_q);

  arb_prio_enc16 u_enc_masked (
    .req   (req_masked),
    .idx   (masked_idx),
    .valid (masked_valid)
  );

  arb_prio_enc16 u_enc_all (
    .req   (req),
    .idx   (all_idx),
    .valid (all_valid)
  );

  // Nothing at or above ptr means the search wraps to the lowest index overall.
  assign sel_idx     = masked_valid ? masked_idx : all_idx;
  assign release_evt = done | ~req[grant_id_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // cnt_q counts completed BUSY cycles, so the last allowed one sees HOLD_MAX-1.
  assign hold_expired = (cnt_q == HoldLast);
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (all_valid) begin
          state_d       = StBusy;
          grant_d       = {{(N_REQ - 1){1'b0}}, 1'b1} << sel_idx;
          grant_id_d    = sel_idx;
          grant_valid_d = 1'b1;
          ptr_d         = sel_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      StBusy: begin
        if (release_evt || hold_expired) begin
          state_d       = StIdle;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          // A coincident release wins over the timer: no pulse.
          timeout_d     = ~release_evt;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_channel_arbiter_16.sv
// Self-checking bench for channel_arbiter_16: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_channel_arbiter_16;

  localparam int unsigned HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req = 16'h0;
  logic        done = 1'b0;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_ten   = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  channel_arbiter_16 #(.HOLD_MAX(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic model_step(input logic [15:0] r, input bit d, input bit rst);
    bit found;
    m_to = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_ten = 0;
    end else if (!m_busy) begin
      if (r != 16'h0) begin
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
          if (!found && r[(m_ptr + k) % 16]) begin
            found   = 1'b1;
            m_owner = (m_ptr + k) % 16;
          end
        end
        m_busy = 1'b1;
        m_ptr  = (m_owner + 1) % 16;
        m_ten  = 0;
      end
    end else if (d || !r[m_owner]) begin
      m_busy = 1'b0;
    end else begin
      m_ten++;
      if (TO_EN && m_ten == HOLD) begin
        m_busy = 1'b0;
        m_to   = 1'b1;
      end
    end
  endtask

  function automatic logic [21:0] exp_vec();
    logic [15:0] g;
    g = 16'h0;
    if (m_busy) g[m_owner] = 1'b1;
    return {g, m_busy ? 4'(m_owner) : 4'h0, m_busy, m_to};
  endfunction

  // Drive inputs for the current cycle, take the edge, sample 1 time unit later.
  task automatic cycle(input logic [15:0] r, input bit d, input bit rst);
    req = r; done = d; reset = rst;
    @(posedge clk);
    model_step(r, d, rst);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    for (int i = 0; i < 3; i++) begin
      cycle(16'($urandom) | 16'h1, 1'b1, 1'b1);
      obs = {grant, grant_id, grant_valid, timeout};
      n_cmp++;
      if (obs !== 22'h0) begin
        n_err++; $display("FAIL reset_state: got %h expected %h", obs, 22'h0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(16'h0000, 1'($urandom), 1'b0);
      obs = {grant, grant_id, grant_valid, timeout};
      n_cmp++;
      if (grant_valid !== 1'b0 || grant_id !== 4'h0 || obs !== exp_vec()) begin
        n_err++; $display("FAIL idle_no_req: got %h expected %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_basic_0081();
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'h0081, 1'b0, 1'b0);
    n_cmp++;
    if (grant !== 16'h0001 || grant_id !== 4'd0 || grant_valid !== 1'b1) begin
      n_err++; $display("FAIL first_grant: got %h/%0d expected 0001/0", grant, grant_id);
    end
    cycle(16'h0081, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0) begin
      n_err++; $display("FAIL done_release: got %h/%b expected 0000/0", grant, grant_valid);
    end
    cycle(16'h0081, 1'b0, 1'b0);
    n_cmp++;
    if (grant !== 16'h0080 || grant_id !== 4'd7) begin
      n_err++; $display("FAIL second_grant: got %h/%0d expected 0080/7", grant, grant_id);
    end
    // Reset while busy drops the grant and rewinds the pointer.
    cycle(16'h0081, 1'b0, 1'b1);
    n_cmp++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_in_busy: got %h/%b expected 0000/0", grant, grant_valid);
    end
    cycle(16'h0081, 1'b0, 1'b0);
    n_cmp++;
    if (grant_id !== 4'd0 || grant_valid !== 1'b1) begin
      n_err++; $display("FAIL ptr_after_reset: got %0d/%b expected 0/1", grant_id, grant_valid);
    end
  endtask

  task automatic test_round_robin();
    cycle(16'h0000, 1'b0, 1'b1);
    for (int n = 0; n < 34; n++) begin
      cycle(16'hFFFF, 1'b1, 1'b0);
      n_cmp++;
      if (n % 2 == 0) begin
        if (grant_valid !== 1'b1 || grant_id !== 4'((n / 2) % 16)) begin
          n_err++;
          $display("FAIL rr_grant_%0d: got %0d/%b expected %0d/1", n, grant_id, grant_valid,
                   (n / 2) % 16);
        end
      end else if (grant_valid !== 1'b0 || grant !== 16'h0) begin
        n_err++; $display("FAIL rr_gap_%0d: got %h/%b expected 0000/0", n, grant, grant_valid);
      end
    end
  endtask

  task automatic test_wrap();
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'h4000, 1'b0, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0);
    cycle(16'h0006, 1'b0, 1'b0);
    n_cmp++;
    if (grant_id !== 4'd1 || grant !== 16'h0002) begin
      n_err++; $display("FAIL wrap_grant: got %h/%0d expected 0002/1", grant, grant_id);
    end
    cycle(16'h0006, 1'b1, 1'b0);
    cycle(16'h0006, 1'b0, 1'b0);
    n_cmp++;
    if (grant_id !== 4'd2 || grant !== 16'h0004) begin
      n_err++; $display("FAIL wrap_ptr: got %h/%0d expected 0004/2", grant, grant_id);
    end
  endtask

  task automatic test_req_drop();
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'h0008, 1'b0, 1'b0);
    cycle(16'h0109, 1'b0, 1'b0);
    n_cmp++;
    if (grant !== 16'h0008 || grant_id !== 4'd3) begin
      n_err++; $display("FAIL busy_hold: got %h/%0d expected 0008/3", grant, grant_id);
    end
    cycle(16'h0101, 1'b0, 1'b0);
    n_cmp++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL drop_release: got %h/%b expected 0000/0", grant, grant_valid);
    end
    cycle(16'h0101, 1'b0, 1'b0);
    n_cmp++;
    if (grant !== 16'h0100 || grant_id !== 4'd8) begin
      n_err++; $display("FAIL drop_next: got %h/%0d expected 0100/8", grant, grant_id);
    end
  endtask

  task automatic test_timeout();
    cycle(16'h0000, 1'b0, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      cycle(16'h0010, 1'b0, 1'b0);
      n_cmp++;
      if (grant !== 16'h0010 || timeout !== 1'b0) begin
        n_err++; $display("FAIL to_hold_%0d: got %h/%b expected 0010/0", i, grant, timeout);
      end
    end
    cycle(16'h0010, 1'b0, 1'b0);
    n_cmp++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0 || timeout !== 1'b1) begin
      n_err++; $display("FAIL to_revoke: got %h/%b expected 0000/1", grant, timeout);
    end
    cycle(16'h0010, 1'b0, 1'b0);
    n_cmp++;
    if (grant !== 16'h0010 || grant_id !== 4'd4 || timeout !== 1'b0) begin
      n_err++; $display("FAIL to_regrant: got %h/%b expected 0010/0", grant, timeout);
    end
    for (int i = 0; i < 3; i++) cycle(16'h0010, 1'b0, 1'b0);
    cycle(16'h0010, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 16'h0000 || timeout !== 1'b0) begin
      n_err++; $display("FAIL to_done_wins: got %h/%b expected 0000/0", grant, timeout);
    end
`else
    for (int i = 0; i < 300; i++) begin
      cycle(16'h0010, 1'b0, 1'b0);
      n_cmp++;
      if (grant !== 16'h0010 || timeout !== 1'b0) begin
        n_err++; $display("FAIL hold_forever_%0d: got %h/%b expected 0010/0", i, grant, timeout);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [21:0] obs;
    logic [15:0] r;
    bit          rst;
    cycle(16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 0) r = r & 16'($urandom) & 16'($urandom);
      if (m_busy && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      rst = ($urandom_range(0, 99) == 0);
      cycle(r, ($urandom_range(0, 3) == 0), rst);
      obs = {grant, grant_id, grant_valid, timeout};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_0081();
    test_round_robin();
    test_wrap();
    test_req_drop();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
